// File: rtl/set_bit_scan_encoder.sv
// Serialises a WIDTH-bit request vector into the binary index of each set bit,
// one index per valid/ready output beat, in LSB-first or MSB-first priority order.
module set_bit_scan_encoder #(
  parameter int  WIDTH     = 8,
  parameter bit  MSB_FIRST = 1'b0,
  localparam int IDX_W     = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic             busy
);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             none_q, none_d;

  logic [IDX_W-1:0] sel_idx;
  logic             found;
  logic [WIDTH-1:0] sel_mask;
  logic             single;

  // NOTE: blocking assignments are correct here; 'found' must be seen by later loop iterations.
  always_comb begin
    sel_idx = '0;
    found   = 1'b0;
    if (MSB_FIRST) begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (!found && pending_q[i]) begin
          sel_idx = IDX_W'(i);
          found   = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (!found && pending_q[i]) begin
          sel_idx = IDX_W'(i);
          found   = 1'b1;
        end
      end
    end
  end

  // x & (x-1) clears the lowest set bit, so a zero result means at most one bit was set.
  assign single   = (pending_q != '0) && ((pending_q & (pending_q - WIDTH'(1))) == '0);
  assign sel_mask = WIDTH'(1) << sel_idx;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == EMIT);
  assign busy      = (state_q != IDLE);
  assign out_idx   = none_q ? '0 : sel_idx;
  assign out_last  = none_q | single;
  assign out_none  = none_q;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    none_d    = none_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          pending_d = in_vec;
          none_d    = (in_vec == '0);
          state_d   = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (out_last) begin
            pending_d = '0;
            none_d    = 1'b0;
            state_d   = IDLE;
          end else begin
            pending_d = pending_q & ~sel_mask;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: reset is sampled on the clock edge only; every register here is small enough to reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      none_q    <= none_d;
    end
  end

endmodule
